// File: rtl/pipelined_adder.sv
// N-bit add/subtract split into S carry-registered segments with valid/ready on both sides.
// Operands travel down the pipeline with each transaction; stage i adds only segment i.
module pipelined_adder #(
  parameter int unsigned N = 16,
  parameter int unsigned S = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic [N:0]   final_sum,
  output logic         ovf
);

  localparam int unsigned W = N / S;

  logic         w_en;
  logic [N-1:0] w_bp;
  logic [N-1:0] w_a_src [S];
  logic [N-1:0] w_b_src [S];
  logic [N-1:0] w_p_src [S];
  logic [N-1:0] w_p_nxt [S];
  logic [W:0]   w_seg   [S];
  logic [S-1:0] w_c_src;
  logic [S-1:0] w_v_src;
  logic [S-1:0] w_c_nxt;
  logic         w_ovf_nxt;

  logic [S-1:0] r_valid;
  logic [S-1:0] r_carry;
  logic [N-1:0] r_a    [S];
  logic [N-1:0] r_b    [S];
  logic [N-1:0] r_psum [S];
  logic         r_ovf;

  // Whole pipeline advances together; a stalled output freezes every stage.
  assign w_en = !r_valid[S-1] || out_ready;

  // Stage inputs and per-segment ripple add.
  always_comb begin
    w_bp       = sub ? ~b : b;
    w_a_src[0] = a;
    w_b_src[0] = w_bp;
    w_p_src[0] = '0;
    w_c_src[0] = sub | cin;
    w_v_src[0] = in_valid;
    for (int i = 1; i < S; i++) begin
      w_a_src[i] = r_a[i-1];
      w_b_src[i] = r_b[i-1];
      w_p_src[i] = r_psum[i-1];
      w_c_src[i] = r_carry[i-1];
      w_v_src[i] = r_valid[i-1];
    end
    for (int i = 0; i < S; i++) begin
      w_seg[i] = {1'b0, w_a_src[i][i*W +: W]} + {1'b0, w_b_src[i][i*W +: W]}
               + (W+1)'(w_c_src[i]);
      w_p_nxt[i]             = w_p_src[i];
      w_p_nxt[i][i*W +: W]   = w_seg[i][W-1:0];
      w_c_nxt[i]             = w_seg[i][W];
    end
    // Same-sign operands producing an opposite-sign result is the MSB carry-in/carry-out mismatch.
    w_ovf_nxt = (w_a_src[S-1][N-1] == w_b_src[S-1][N-1]) &&
                (w_p_nxt[S-1][N-1] != w_a_src[S-1][N-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_carry <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < S; i++) begin
        r_a[i]    <= '0;
        r_b[i]    <= '0;
        r_psum[i] <= '0;
      end
    end else if (w_en) begin
      r_valid <= w_v_src;
      r_carry <= w_c_nxt;
      r_ovf   <= w_ovf_nxt;
      for (int i = 0; i < S; i++) begin
        r_a[i]    <= w_a_src[i];
        r_b[i]    <= w_b_src[i];
        r_psum[i] <= w_p_nxt[i];
      end
    end
  end

  assign in_ready  = w_en;
  assign out_valid = r_valid[S-1];
  assign sum       = r_psum[S-1];
  assign cout      = r_carry[S-1];
  assign final_sum = {r_carry[S-1], r_psum[S-1]};
  assign ovf       = r_ovf;

endmodule
